// File: rtl/pusch_mod_pkg.sv
// Shared definitions for the PUSCH modulation mapper/demapper family:
// default sample width, QPSK bit order and demapper FSM state encoding.
package pusch_mod_pkg;

  localparam int LUT_WIDTH_DEFAULT = 18;

  // The mapper consumes bit 1 (I) before bit 0 (Q); the demapper emits in the same order.
  localparam bit QPSK_I_FIRST = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    I_BIT = 2'd1,
    Q_BIT = 2'd2
  } demap_state_t;

endpackage

// File: rtl/qpsk_hard_decision.sv
// Combinational QPSK sign slicer: bit = 1 for negative samples, 0 for zero or positive.
module qpsk_hard_decision #(
  parameter int WIDTH = 18
) (
  input  logic signed [WIDTH-1:0] sym_i,
  input  logic signed [WIDTH-1:0] sym_q,
  output logic        [1:0]       bits
);

  // bits[1] is the I decision, bits[0] the Q decision, matching mapper input bit order.
  assign bits = {sym_i[WIDTH-1], sym_q[WIDTH-1]};

endmodule

// File: rtl/qpsk_demapper.sv
// QPSK hard-decision demapper: one I/Q symbol in, two serial bits out with the
// raw sample carried alongside each bit as its soft value.
module qpsk_demapper
  import pusch_mod_pkg::*;
#(
  parameter int LUT_WIDTH = LUT_WIDTH_DEFAULT
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        EN_DEMAP,
  input  logic signed [LUT_WIDTH-1:0] Sym_I,
  input  logic signed [LUT_WIDTH-1:0] Sym_Q,
  input  logic                        Sym_Last,
  input  logic                        Sym_Valid,
  output logic                        Sym_Ready,
  output logic                        Bit_Out,
  output logic signed [LUT_WIDTH-1:0] Soft_Out,
  output logic                        Bit_Last,
  output logic                        Bit_Valid,
  input  logic                        Bit_Ready
);

  demap_state_t                state_reg;
  logic signed [LUT_WIDTH-1:0] hold_i_reg;
  logic signed [LUT_WIDTH-1:0] hold_q_reg;
  logic                        hold_last_reg;
  logic [1:0]                  hold_bits_reg;
  logic [1:0]                  in_bits;
  logic                        accept;
  logic                        first_bit;
  logic signed [LUT_WIDTH-1:0] first_soft;
  logic                        second_bit;
  logic signed [LUT_WIDTH-1:0] second_soft;

  qpsk_hard_decision #(.WIDTH(LUT_WIDTH)) u_slicer (
    .sym_i (Sym_I),
    .sym_q (Sym_Q),
    .bits  (in_bits)
  );

  // Gated by RST so the handshake drops the moment reset asserts.
  always_comb begin
    Sym_Ready = 1'b0;
    if (RST) begin
      case (state_reg)
        IDLE:    Sym_Ready = EN_DEMAP;
        Q_BIT:   Sym_Ready = EN_DEMAP && Bit_Ready;
        default: Sym_Ready = 1'b0;
      endcase
    end
  end

  assign accept      = Sym_Valid && Sym_Ready;
  assign first_bit   = QPSK_I_FIRST ? in_bits[1] : in_bits[0];
  assign first_soft  = QPSK_I_FIRST ? Sym_I : Sym_Q;
  assign second_bit  = QPSK_I_FIRST ? hold_bits_reg[0] : hold_bits_reg[1];
  assign second_soft = QPSK_I_FIRST ? hold_q_reg : hold_i_reg;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg     <= IDLE;
      hold_i_reg    <= '0;
      hold_q_reg    <= '0;
      hold_last_reg <= 1'b0;
      hold_bits_reg <= 2'b00;
      Bit_Valid     <= 1'b0;
      Bit_Out       <= 1'b0;
      Soft_Out      <= '0;
      Bit_Last      <= 1'b0;
    end else if (accept) begin
      // Covers both IDLE and back-to-back acceptance from Q_BIT.
      state_reg     <= I_BIT;
      hold_i_reg    <= Sym_I;
      hold_q_reg    <= Sym_Q;
      hold_last_reg <= Sym_Last;
      hold_bits_reg <= in_bits;
      Bit_Valid     <= 1'b1;
      Bit_Out       <= first_bit;
      Soft_Out      <= first_soft;
      Bit_Last      <= 1'b0;
    end else begin
      case (state_reg)
        I_BIT: begin
          if (Bit_Ready) begin
            state_reg <= Q_BIT;
            Bit_Out   <= second_bit;
            Soft_Out  <= second_soft;
            Bit_Last  <= hold_last_reg;
          end
        end
        Q_BIT: begin
          if (Bit_Ready) begin
            state_reg <= IDLE;
            Bit_Valid <= 1'b0;
            Bit_Last  <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qpsk_demapper.sv
// Self-checking bench for qpsk_demapper: behavioural bit-queue model plus
// directed literal checks and a randomized handshake phase.
module tb_qpsk_demapper;

  localparam int W = 18;

  logic                CLK = 1'b0;
  logic                RST = 1'b0;
  logic                EN_DEMAP = 1'b0;
  logic signed [W-1:0] Sym_I = '0;
  logic signed [W-1:0] Sym_Q = '0;
  logic                Sym_Last = 1'b0;
  logic                Sym_Valid = 1'b0;
  logic                Sym_Ready;
  logic                Bit_Out;
  logic signed [W-1:0] Soft_Out;
  logic                Bit_Last;
  logic                Bit_Valid;
  logic                Bit_Ready = 1'b0;

  qpsk_demapper #(.LUT_WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .EN_DEMAP(EN_DEMAP),
    .Sym_I(Sym_I), .Sym_Q(Sym_Q), .Sym_Last(Sym_Last),
    .Sym_Valid(Sym_Valid), .Sym_Ready(Sym_Ready),
    .Bit_Out(Bit_Out), .Soft_Out(Soft_Out), .Bit_Last(Bit_Last),
    .Bit_Valid(Bit_Valid), .Bit_Ready(Bit_Ready)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic b;
    int   s;
    logic l;
    int   cyc;
  } bit_t;

  bit_t exp_q[$];
  bit_t out_log[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cycle = 0;
  bit   rnd_mode = 1'b0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cycle);
    end
  endtask

  // Reference model: each accepted symbol becomes two queued bits, I then Q.
  initial begin
    forever begin
      @(negedge CLK);
      cycle++;
      if (!RST) begin
        exp_q.delete();
        check("reset_bit_valid", longint'(Bit_Valid), 0);
        check("reset_sym_ready", longint'(Sym_Ready), 0);
      end else begin
        check("sym_ready", longint'(Sym_Ready),
              longint'(EN_DEMAP && (exp_q.size() == 0 || (exp_q.size() == 1 && Bit_Ready))));
        check("bit_valid", longint'(Bit_Valid), longint'(exp_q.size() != 0));
        if (Bit_Valid && exp_q.size() != 0) begin
          check("bit_out", longint'(Bit_Out), longint'(exp_q[0].b));
          check("soft_out", longint'(int'(Soft_Out)), longint'(exp_q[0].s));
          check("bit_last", longint'(Bit_Last), longint'(exp_q[0].l));
          if (Bit_Ready) begin
            bit_t e;
            e = exp_q.pop_front();
            e.cyc = cycle;
            out_log.push_back(e);
            $display("bit %0d soft %0d last %0d cycle %0d", e.b, e.s, e.l, cycle);
          end
        end
        if (Sym_Valid && Sym_Ready) begin
          bit_t bi, bq;
          bi.s = int'(Sym_I); bi.b = (bi.s < 0); bi.l = 1'b0; bi.cyc = 0;
          bq.s = int'(Sym_Q); bq.b = (bq.s < 0); bq.l = Sym_Last; bq.cyc = 0;
          exp_q.push_back(bi);
          exp_q.push_back(bq);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (rnd_mode) begin
        Bit_Ready = ($urandom_range(0, 3) != 0);
        EN_DEMAP  = ($urandom_range(0, 7) != 0);
      end
    end
  end

  task automatic send(input int si, input int sq, input bit last);
    int n = 0;
    Sym_I = W'(si); Sym_Q = W'(sq); Sym_Last = last; Sym_Valid = 1'b1;
    @(negedge CLK);
    while (!Sym_Ready && n < 60) begin
      @(negedge CLK);
      n++;
    end
    if (!Sym_Ready) check("send_timeout", 1, 0);
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge CLK);
    while ((exp_q.size() != 0 || Bit_Valid) && n < 300) begin
      @(negedge CLK);
      n++;
    end
    if (exp_q.size() != 0 || Bit_Valid) check("drain_timeout", 1, 0);
    @(posedge CLK);
    #1;
  endtask

  task automatic check_log(input string nm, input int bits[], input int softs[]);
    check({nm, "_count"}, out_log.size(), bits.size());
    for (int k = 0; k < bits.size() && k < out_log.size(); k++) begin
      check({nm, "_bit"}, longint'(out_log[k].b), bits[k]);
      if (softs.size() > k) check({nm, "_soft"}, out_log[k].s, softs[k]);
    end
  endtask

  initial begin
    int none[];
    int b4[], s4[], b2[], s2[];
    none = new[0];

    repeat (3) @(negedge CLK);
    check("reset_bit_out", longint'(Bit_Out), 0);
    check("reset_soft_out", longint'(int'(Soft_Out)), 0);
    check("reset_bit_last", longint'(Bit_Last), 0);
    @(posedge CLK); #1;
    RST = 1'b1; EN_DEMAP = 1'b1; Bit_Ready = 1'b1;

    // Four constellation points with a free-running sink.
    out_log.delete();
    send(1, 1, 0); send(1, -1, 0); send(-1, 1, 0); send(-1, -1, 0);
    Sym_Valid = 1'b0;
    wait_idle();
    b4 = '{0, 0, 0, 1, 1, 0, 1, 1};
    s4 = '{1, 1, 1, -1, -1, 1, -1, -1};
    check_log("constellation", b4, s4);

    // Sustained throughput: 16 bits on consecutive cycles.
    out_log.delete();
    for (int k = 0; k < 8; k++) send(k + 1, -(k + 1), 0);
    Sym_Valid = 1'b0;
    wait_idle();
    check("stream_count", out_log.size(), 16);
    if (out_log.size() == 16) check("stream_span", out_log[15].cyc - out_log[0].cyc, 15);

    // Zero and extreme values.
    out_log.delete();
    send(0, -131072, 0); send(-1, 131071, 0);
    Sym_Valid = 1'b0;
    wait_idle();
    b4 = '{0, 1, 1, 0};
    s4 = '{0, -131072, -1, 131071};
    check_log("extremes", b4, s4);

    // Sink stall during the I-bit.
    out_log.delete();
    Bit_Ready = 1'b0;
    send(-5, 7, 0);
    Sym_Valid = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      check("stall_bit_out", longint'(Bit_Out), 1);
      check("stall_soft_out", longint'(int'(Soft_Out)), -5);
      check("stall_sym_ready", longint'(Sym_Ready), 0);
    end
    @(posedge CLK); #1;
    Bit_Ready = 1'b1;
    wait_idle();
    b2 = '{1, 0};
    s2 = '{-5, 7};
    check_log("stall", b2, s2);

    // Last flag on the third symbol.
    out_log.delete();
    send(2, 3, 0); send(-2, 3, 0); send(2, -3, 1);
    Sym_Valid = 1'b0;
    wait_idle();
    check("last_count", out_log.size(), 6);
    for (int k = 0; k < out_log.size(); k++)
      check("last_flag", longint'(out_log[k].l), (k == 5) ? 1 : 0);

    // Enable dropped while the I-bit is pending.
    out_log.delete();
    Bit_Ready = 1'b0;
    send(4, -6, 0);
    EN_DEMAP = 1'b0;
    Sym_I = 18'sd7; Sym_Q = 18'sd7;
    Bit_Ready = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      check("en_low_sym_ready", longint'(Sym_Ready), 0);
    end
    @(posedge CLK); #1;
    b2 = '{0, 1};
    s2 = '{4, -6};
    check_log("en_drop", b2, s2);
    Sym_Valid = 1'b0;
    EN_DEMAP = 1'b1;

    // Asynchronous reset while the Q-bit is pending.
    Bit_Ready = 1'b0;
    send(3, -4, 0);
    Sym_Valid = 1'b0;
    Bit_Ready = 1'b1;
    @(posedge CLK); #1;
    Bit_Ready = 1'b0;
    #2;
    RST = 1'b0;
    #1;
    check("async_rst_bit_valid", longint'(Bit_Valid), 0);
    check("async_rst_sym_ready", longint'(Sym_Ready), 0);
    @(posedge CLK); #1;
    RST = 1'b1;
    out_log.delete();
    Bit_Ready = 1'b1;
    send(-9, 2, 0);
    Sym_Valid = 1'b0;
    wait_idle();
    b2 = '{1, 0};
    s2 = '{-9, 2};
    check_log("post_reset", b2, s2);

    // Randomized traffic with random sink stalls and enable toggling.
    rnd_mode = 1'b1;
    for (int k = 0; k < 300; k++) begin
      int vi, vq;
      case ($urandom_range(0, 5))
        0: vi = 0;
        1: vi = -131072;
        2: vi = 131071;
        3: vi = -1;
        default: vi = int'($signed(18'($urandom)));
      endcase
      vq = ($urandom_range(0, 3) == 0) ? 0 : int'($signed(18'($urandom)));
      send(vi, vq, $urandom_range(0, 4) == 0);
      if ($urandom_range(0, 3) == 0) begin
        Sym_Valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge CLK);
        #1;
      end
    end
    Sym_Valid = 1'b0;
    rnd_mode = 1'b0;
    @(posedge CLK); #2;
    Bit_Ready = 1'b1;
    EN_DEMAP = 1'b1;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
